// File: rtl/branch_predict_resolve_if.sv
`default_nettype none
// ============================================================================
// Module   : branch_predict_resolve_if
// Purpose  : Fetch lookup and Execute resolution bundle for the branch unit.
// Revision : 1.0
// ============================================================================
interface branch_predict_resolve_if #(
   parameter int XLEN = 32
);
   logic [XLEN-1:0] PCF;
   logic            PredTakenF;
   logic [XLEN-1:0] PredTargetF;
   logic            ValidE;
   logic [XLEN-1:0] PCE;
   logic [XLEN-1:0] PCPlus4E;
   logic [XLEN-1:0] TargetE;
   logic            JumpE;
   logic            BranchE;
   logic [2:0]      BranchTypeE;
   logic            Zero;
   logic            LSB;
   logic            trap;
   logic            mret;
   logic            PredTakenE;
   logic [XLEN-1:0] PredTargetE;
   logic            RedirectE;
   logic [1:0]      RedirectSelE;
   logic            ActualTakenE;

   modport master (
      output PCF, ValidE, PCE, PCPlus4E, TargetE, JumpE, BranchE, BranchTypeE,
             Zero, LSB, trap, mret, PredTakenE, PredTargetE,
      input  PredTakenF, PredTargetF, RedirectE, RedirectSelE, ActualTakenE
   );

   modport slave (
      input  PCF, ValidE, PCE, PCPlus4E, TargetE, JumpE, BranchE, BranchTypeE,
             Zero, LSB, trap, mret, PredTakenE, PredTargetE,
      output PredTakenF, PredTargetF, RedirectE, RedirectSelE, ActualTakenE
   );
endinterface
`default_nettype wire

// File: rtl/branch_predict_resolve.sv
`default_nettype none
// ============================================================================
// Module   : branch_predict_resolve
// Purpose  : Direct-mapped BTB with 2-bit counters plus Execute-stage resolve.
// Revision : 1.0
// ============================================================================
module branch_predict_resolve #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 64
) (
   input  logic                    clk,
   input  logic                    rst,
   branch_predict_resolve_if.slave bus
);
   localparam int IDXW = $clog2(DEPTH);
   localparam int TAGW = XLEN - 2 - IDXW;

   logic [DEPTH-1:0] r_valid;
   logic [TAGW-1:0]  r_tag    [DEPTH];
   logic [XLEN-1:0]  r_target [DEPTH];
   logic [1:0]       r_ctr    [DEPTH];

   logic [IDXW-1:0]  w_idx_f;
   logic [IDXW-1:0]  w_idx_e;
   logic [TAGW-1:0]  w_tag_f;
   logic [TAGW-1:0]  w_tag_e;
   logic             w_hit_f;
   logic             w_hit_e;
   logic             w_cond;
   logic             w_taken;
   logic             w_upd;
   logic             w_wr_entry;
   logic [1:0]       w_ctr_e;
   logic [1:0]       w_ctr_inc;
   logic [1:0]       w_ctr_dec;
   logic             w_redirect;
   logic [1:0]       w_sel;
   logic             w_unused;

   assign w_idx_f = bus.PCF[IDXW+1:2];
   assign w_tag_f = bus.PCF[XLEN-1:IDXW+2];
   assign w_idx_e = bus.PCE[IDXW+1:2];
   assign w_tag_e = bus.PCE[XLEN-1:IDXW+2];

   // Fetch reads the table as it stands; same-cycle updates are not bypassed.
   assign w_hit_f         = r_valid[w_idx_f] && (r_tag[w_idx_f] == w_tag_f);
   assign bus.PredTakenF  = w_hit_f && r_ctr[w_idx_f][1];
   assign bus.PredTargetF = r_target[w_idx_f];

   assign w_hit_e   = r_valid[w_idx_e] && (r_tag[w_idx_e] == w_tag_e);
   assign w_ctr_e   = r_ctr[w_idx_e];
   assign w_ctr_inc = (w_ctr_e == 2'b11) ? 2'b11 : w_ctr_e + 2'b01;
   assign w_ctr_dec = (w_ctr_e == 2'b00) ? 2'b00 : w_ctr_e - 2'b01;

   always_comb begin
      w_cond = bus.Zero;
      case (bus.BranchTypeE)
         3'b000:          w_cond = bus.Zero;
         3'b001:          w_cond = ~bus.Zero;
         3'b100, 3'b110:  w_cond = bus.LSB;
         3'b101, 3'b111:  w_cond = ~bus.LSB;
         default:         w_cond = bus.Zero;
      endcase
   end

   assign w_taken          = bus.ValidE && (bus.JumpE || (bus.BranchE && w_cond));
   assign bus.ActualTakenE = w_taken;

   always_comb begin
      w_redirect = 1'b0;
      w_sel      = 2'b00;
      if (bus.ValidE && (bus.trap || bus.mret)) begin
         w_redirect = 1'b1;
         w_sel      = 2'b10;
      end else if (w_taken && (!bus.PredTakenE || (bus.PredTargetE != bus.TargetE))) begin
         w_redirect = 1'b1;
         w_sel      = 2'b00;
      end else if (bus.ValidE && !w_taken && bus.PredTakenE) begin
         w_redirect = 1'b1;
         w_sel      = 2'b01;
      end
   end

   assign bus.RedirectE    = w_redirect;
   assign bus.RedirectSelE = w_sel;

   assign w_upd      = bus.ValidE && !bus.trap && !bus.mret;
   assign w_wr_entry = w_upd && (bus.JumpE || (bus.BranchE && w_cond));

   // Valid bits and counters are cleared by reset; tag/target are not.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_ctr[i] <= 2'b01;
         end
      end else if (w_upd) begin
         if (bus.JumpE) begin
            r_valid[w_idx_e] <= 1'b1;
            r_ctr[w_idx_e]   <= 2'b11;
         end else if (bus.BranchE) begin
            if (w_cond) begin
               r_valid[w_idx_e] <= 1'b1;
               r_ctr[w_idx_e]   <= w_hit_e ? w_ctr_inc : 2'b10;
            end else begin
               r_ctr[w_idx_e]   <= w_ctr_dec;
            end
         end else if (bus.PredTakenE) begin
            // Non-control instruction predicted taken: drop the aliasing entry.
            r_valid[w_idx_e] <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && w_wr_entry) begin
         r_tag[w_idx_e]    <= w_tag_e;
         r_target[w_idx_e] <= bus.TargetE;
      end
   end

   assign w_unused = &{1'b0, bus.PCPlus4E, bus.PCF[1:0], bus.PCE[1:0]};
endmodule
`default_nettype wire

// File: tb/tb_branch_predict_resolve.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_predict_resolve
// Purpose  : Directed scoreboard bench driving DEPTH=64 and DEPTH=4 units.
// Revision : 1.0
// ============================================================================
module tb_branch_predict_resolve;
   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pcf, pce, tgt, ptgt_e;
   logic        valid_e, jump, branch, zero, lsb, trap, mret, ptk_e;
   logic [2:0]  btype;

   always #5 clk = ~clk;

   branch_predict_resolve_if #(.XLEN(32)) bus64 ();
   branch_predict_resolve_if #(.XLEN(32)) bus4 ();

   assign bus64.PCF = pcf;          assign bus4.PCF = pcf;
   assign bus64.ValidE = valid_e;   assign bus4.ValidE = valid_e;
   assign bus64.PCE = pce;          assign bus4.PCE = pce;
   assign bus64.PCPlus4E = pce + 4; assign bus4.PCPlus4E = pce + 4;
   assign bus64.TargetE = tgt;      assign bus4.TargetE = tgt;
   assign bus64.JumpE = jump;       assign bus4.JumpE = jump;
   assign bus64.BranchE = branch;   assign bus4.BranchE = branch;
   assign bus64.BranchTypeE = btype; assign bus4.BranchTypeE = btype;
   assign bus64.Zero = zero;        assign bus4.Zero = zero;
   assign bus64.LSB = lsb;          assign bus4.LSB = lsb;
   assign bus64.trap = trap;        assign bus4.trap = trap;
   assign bus64.mret = mret;        assign bus4.mret = mret;
   assign bus64.PredTakenE = ptk_e; assign bus4.PredTakenE = ptk_e;
   assign bus64.PredTargetE = ptgt_e; assign bus4.PredTargetE = ptgt_e;

   branch_predict_resolve #(.XLEN(32), .DEPTH(64)) dut64 (.clk(clk), .rst(rst), .bus(bus64.slave));
   branch_predict_resolve #(.XLEN(32), .DEPTH(4))  dut4  (.clk(clk), .rst(rst), .bus(bus4.slave));

   typedef struct {
      string       name;
      int          sig;
      logic [31:0] val;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;

   function automatic logic [31:0] obs(input int d, input int s);
      if (d == 0) begin
         case (s)
            0:       return {31'b0, bus64.PredTakenF};
            1:       return bus64.PredTargetF;
            2:       return {31'b0, bus64.RedirectE};
            3:       return {30'b0, bus64.RedirectSelE};
            default: return {31'b0, bus64.ActualTakenE};
         endcase
      end
      case (s)
         0:       return {31'b0, bus4.PredTakenF};
         1:       return bus4.PredTargetF;
         2:       return {31'b0, bus4.RedirectE};
         3:       return {30'b0, bus4.RedirectSelE};
         default: return {31'b0, bus4.ActualTakenE};
      endcase
   endfunction

   // Condition outcome straight from the funct3 table.
   function automatic logic cond_ref(input logic [2:0] bt, input logic z, input logic l);
      case (bt)
         3'b000:         return z;
         3'b001:         return !z;
         3'b100, 3'b110: return l;
         3'b101, 3'b111: return !l;
         default:        return z;
      endcase
   endfunction

   task automatic push(input string n, input int s, input logic [31:0] v);
      exp_t e;
      e.name = n;
      e.sig  = s;
      e.val  = v;
      sb.push_back(e);
   endtask

   task automatic sample();
      #1;
      while (sb.size() > 0) begin
         exp_t        e;
         logic [31:0] o;
         e = sb.pop_front();
         for (int d = 0; d < 2; d++) begin
            o = obs(d, e.sig);
            checks++;
            assert (o === e.val) else begin
               errors++;
               $error("FAIL %s dut%0d sig%0d observed=%h expected=%h",
                      e.name, (d == 0) ? 64 : 4, e.sig, o, e.val);
            end
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic step();
      sample();
      tick();
   endtask

   task automatic idle_e();
      valid_e = 1'b0; jump = 1'b0; branch = 1'b0; btype = 3'b000;
      zero = 1'b0; lsb = 1'b0; trap = 1'b0; mret = 1'b0;
      ptk_e = 1'b0; ptgt_e = 32'h0; pce = 32'h0; tgt = 32'h0;
   endtask

   task automatic ex(input logic [31:0] pc, input logic [31:0] t, input logic j,
                     input logic b, input logic [2:0] bt, input logic z, input logic l,
                     input logic tr, input logic mr, input logic pk, input logic [31:0] pt);
      valid_e = 1'b1; pce = pc; tgt = t; jump = j; branch = b; btype = bt;
      zero = z; lsb = l; trap = tr; mret = mr; ptk_e = pk; ptgt_e = pt;
   endtask

   task automatic exp_e(input string n, input logic r, input logic [1:0] s, input logic a);
      push({n, ".redir"}, 2, {31'b0, r});
      push({n, ".sel"}, 3, {30'b0, s});
      push({n, ".taken"}, 4, {31'b0, a});
   endtask

   task automatic look(input string n, input logic [31:0] pc, input logic pt,
                       input logic [31:0] tg, input bit chk_t);
      pcf = pc;
      push({n, ".ptaken"}, 0, {31'b0, pt});
      if (chk_t) push({n, ".ptarget"}, 1, tg);
   endtask

   initial begin
      logic c;
      rst = 1'b1;
      pcf = 32'h0;
      idle_e();
      tick();

      // Outputs stay combinational during reset, and no update is taken.
      ex(32'h300, 32'h700, 1, 0, 3'b000, 0, 0, 0, 0, 0, 32'h0);
      exp_e("in_reset", 1, 2'b00, 1);
      look("in_reset", 32'h300, 0, 32'h0, 0);
      step();
      rst = 1'b0;
      idle_e();
      look("post_reset_0x300", 32'h300, 0, 32'h0, 0);
      exp_e("bubble", 0, 2'b00, 0);
      sample();
      for (int i = 0; i < 64; i++) begin
         look("reset_sweep", i * 4, 0, 32'h0, 0);
         sample();
      end

      // Branch condition decode at an index of its own.
      for (int bt = 0; bt < 8; bt++) begin
         for (int zl = 0; zl < 4; zl++) begin
            c = cond_ref(bt[2:0], zl[1], zl[0]);
            ex(32'h1004, 32'h2000, 0, 1, bt[2:0], zl[1], zl[0], 0, 0, 0, 32'h0);
            exp_e("cond", c, 2'b00, c);
            step();
         end
      end

      // Training and steady state.
      ex(32'h100, 32'h80, 0, 1, 3'b000, 1, 0, 0, 0, 0, 32'h0);
      exp_e("train_miss", 1, 2'b00, 1);
      look("pre_train", 32'h100, 0, 32'h0, 0);
      step();
      ex(32'h100, 32'h80, 0, 1, 3'b000, 1, 0, 0, 0, 1, 32'h80);
      exp_e("train_hit", 0, 2'b00, 1);
      look("after_alloc", 32'h100, 1, 32'h80, 1);
      step();
      ex(32'h100, 32'h80, 0, 1, 3'b000, 0, 0, 0, 0, 1, 32'h80);
      exp_e("nt1", 1, 2'b01, 0);
      look("ctr11", 32'h100, 1, 32'h80, 1);
      step();
      exp_e("nt2", 1, 2'b01, 0);
      look("ctr10", 32'h100, 1, 32'h80, 1);
      step();
      idle_e();
      look("ctr01", 32'h100, 0, 32'h80, 1);
      step();

      // Counter saturation at both ends.
      ex(32'h100, 32'h80, 0, 1, 3'b000, 1, 0, 0, 0, 0, 32'h0);
      exp_e("sat_t1", 1, 2'b00, 1);
      step();
      ex(32'h100, 32'h80, 0, 1, 3'b000, 1, 0, 0, 0, 1, 32'h80);
      exp_e("sat_t2", 0, 2'b00, 1);
      step();
      exp_e("sat_t3", 0, 2'b00, 1);
      step();
      ex(32'h100, 32'h80, 0, 1, 3'b000, 0, 0, 0, 0, 1, 32'h80);
      exp_e("sat_nt1", 1, 2'b01, 0);
      step();
      idle_e();
      look("sat_hi", 32'h100, 1, 32'h80, 1);
      sample();
      ex(32'h100, 32'h80, 0, 1, 3'b000, 0, 0, 0, 0, 1, 32'h80);
      exp_e("sat_nt2", 1, 2'b01, 0);
      step();
      ex(32'h100, 32'h80, 0, 1, 3'b000, 0, 0, 0, 0, 0, 32'h0);
      exp_e("sat_nt3", 0, 2'b00, 0);
      step();
      exp_e("sat_nt4", 0, 2'b00, 0);
      step();
      ex(32'h100, 32'h80, 0, 1, 3'b000, 1, 0, 0, 0, 0, 32'h0);
      exp_e("sat_t4", 1, 2'b00, 1);
      step();
      idle_e();
      look("sat_lo", 32'h100, 0, 32'h80, 1);
      sample();

      // Jump allocation and target change, with same-cycle lookup.
      ex(32'h200, 32'h300, 1, 0, 3'b000, 0, 0, 0, 0, 0, 32'h0);
      exp_e("jalr_alloc", 1, 2'b00, 1);
      step();
      ex(32'h200, 32'h340, 1, 0, 3'b000, 0, 0, 0, 0, 1, 32'h300);
      exp_e("jalr_newtgt", 1, 2'b00, 1);
      look("jalr_old_seen", 32'h200, 1, 32'h300, 1);
      step();
      idle_e();
      look("jalr_updated", 32'h200, 1, 32'h340, 1);
      sample();
      look("tag_mismatch", 32'h100, 0, 32'h340, 1);
      sample();

      // Alias invalidation.
      ex(32'h100, 32'h80, 0, 1, 3'b000, 1, 0, 0, 0, 0, 32'h0);
      exp_e("alias_train", 1, 2'b00, 1);
      step();
      idle_e();
      look("alias_trained", 32'h100, 1, 32'h80, 1);
      sample();
      ex(32'h200, 32'h0, 0, 0, 3'b000, 0, 0, 0, 0, 1, 32'h80);
      exp_e("alias_hit", 1, 2'b01, 0);
      step();
      idle_e();
      look("alias_gone", 32'h100, 0, 32'h80, 1);
      sample();

      // Trap/mret priority and update suppression.
      ex(32'h100, 32'h80, 0, 1, 3'b000, 1, 0, 0, 0, 0, 32'h0);
      exp_e("retrain", 1, 2'b00, 1);
      step();
      ex(32'h100, 32'hA0, 0, 1, 3'b000, 1, 0, 1, 0, 0, 32'h0);
      exp_e("trap_prio", 1, 2'b10, 1);
      step();
      idle_e();
      look("trap_nowrite", 32'h100, 1, 32'h80, 1);
      sample();
      ex(32'h100, 32'h80, 0, 1, 3'b000, 0, 0, 0, 1, 1, 32'h80);
      exp_e("mret_prio", 1, 2'b10, 0);
      step();
      ex(32'h100, 32'h80, 0, 1, 3'b000, 0, 0, 0, 0, 1, 32'h80);
      exp_e("post_mret_nt", 1, 2'b01, 0);
      look("mret_nowrite", 32'h100, 1, 32'h80, 1);
      step();
      idle_e();
      look("post_mret_dec", 32'h100, 0, 32'h80, 1);
      sample();

      // ValidE=0 gating.
      ex(32'h100, 32'h500, 1, 0, 3'b000, 0, 0, 0, 0, 0, 32'h0);
      valid_e = 1'b0;
      exp_e("bubble_jump", 0, 2'b00, 0);
      step();
      ex(32'h100, 32'h500, 0, 0, 3'b000, 0, 0, 1, 0, 1, 32'h0);
      valid_e = 1'b0;
      exp_e("bubble_trap", 0, 2'b00, 0);
      step();
      idle_e();
      look("bubble_nowrite", 32'h100, 0, 32'h80, 1);
      sample();

      // Same-index lookup/update collision.
      ex(32'h100, 32'h600, 1, 0, 3'b000, 0, 0, 0, 0, 0, 32'h0);
      exp_e("collide", 1, 2'b00, 1);
      look("collide_old", 32'h100, 0, 32'h80, 1);
      step();
      idle_e();
      look("collide_new", 32'h100, 1, 32'h600, 1);
      sample();

      // Mid-stream reset discards learned state.
      rst = 1'b1;
      step();
      rst = 1'b0;
      look("rst_mid_0x100", 32'h100, 0, 32'h0, 0);
      sample();
      look("rst_mid_0x1004", 32'h1004, 0, 32'h0, 0);
      sample();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
`default_nettype wire
